// File: rtl/seq_divider_arb.sv
// rtl/seq_divider_arb.sv - multi-cycle restoring divider with peer-exclusion handshake
module seq_divider_arb #(
  parameter int WIDTH   = 64,
  parameter int NPEER   = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [NPEER-1:0] peer_ack_in,
  input  logic [NPEER-1:0] peer_working,
  output logic [NPEER-1:0] ack_to_peer,
  output logic             working,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             timeout_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    iter_q, iter_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             tmo_q, tmo_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;

  assign working     = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign ack_to_peer = (state_q == S_IDLE && !start) ? peer_working : '0;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign timeout_err = tmo_q;

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    iter_d    = iter_q;
    wait_d    = wait_q;
    primed_d  = primed_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    dbz_d     = dbz_q;
    tmo_d     = tmo_q;
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d    = a;
          dvs_d    = b;
          dbz_d    = 1'b0;
          tmo_d    = 1'b0;
          wait_d   = '0;
          primed_d = 1'b0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // The first REQ cycle only raises the request; acks are judged from the next one on.
        if (!primed_q) begin
          primed_d = 1'b1;
        end else if (&peer_ack_in) begin
          if (dvs_q == '0) begin
            quot_d  = '0;
            remo_d  = '0;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            iter_d  = CW'(WIDTH);
            rem_d   = '0;
            state_d = S_CALC;
          end
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          quot_d  = '0;
          remo_d  = '0;
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_CALC: begin
        // The dividend register shifts left and collects quotient bits at its LSB.
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        iter_d = iter_q - CW'(1);
        if (iter_q == CW'(1)) begin
          quot_d  = dvd_d;
          remo_d  = rem_d;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      iter_q   <= '0;
      wait_q   <= '0;
      primed_q <= 1'b0;
      quot_q   <= '0;
      remo_q   <= '0;
      dbz_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      iter_q   <= iter_d;
      wait_q   <= wait_d;
      primed_q <= primed_d;
      quot_q   <= quot_d;
      remo_q   <= remo_d;
      dbz_q    <= dbz_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule
